cla_adder_pipe: RTL and testbench

Parametrised, two-stage pipelined block carry-lookahead adder/subtractor with a valid/ready stream interface. Operands split into GROUP-bit lookahead groups. Stage 1 forms bit and group propagate/generate. Stage 2 resolves group carries through a second lookahead level, then forms sum and flags. Drop-in arithmetic unit for datapaths wider than 4 bits that need back-pressure and a registered output.

---
 rtl/cla_adder_pipe.sv | 132 +++++++++++++
 tb/tb_cla_adder_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined block carry-lookahead adder/subtractor with valid/ready.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   out_valid/out_ready result handshake (sum, cout, ovf, zero)
//   sub=1 computes a-b (cin ignored, cout=1 means no borrow); ovf is signed overflow
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP;

    if (WIDTH < 4 || WIDTH % GROUP != 0 || !(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_bad_params
        $error("cla_adder_pipe: illegal WIDTH/GROUP combination");
    end

    // Carry out of position n-1 in sum-of-products lookahead form:
    // OR over j<n of (gv[j] & pv[j+1..n-1]) plus (c & pv[0..n-1]); no term depends on another carry.
    function automatic logic la(input logic [WIDTH-1:0] pv, input logic [WIDTH-1:0] gv,
                                input logic c, input int n);
        logic acc;
        logic t;
        acc = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            t = gv[j];
            for (int m = 0; m < WIDTH; m++) t = (m > j && m < n) ? t & pv[m] : t;
            acc = (j < n) ? acc | t : acc;
        end
        t = c;
        for (int m = 0; m < WIDTH; m++) t = (m < n) ? t & pv[m] : t;
        return acc | t;
    endfunction

    logic             adv1, adv2;
    logic [WIDTH-1:0] b_eff, p, g;
    logic             c_eff;
    logic [NG-1:0]    grp_p, grp_g;

    logic             s1_valid, s1_c, s1_amsb, s1_bmsb;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gp, s1_gg;

    logic [NG-1:0]    gc;
    logic [WIDTH-1:0] c, nsum;
    logic             ncout, novf;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    always_comb begin
        b_eff = sub ? ~b : b;
        c_eff = sub | cin;
        p     = a ^ b_eff;
        g     = a & b_eff;
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < NG; k++) begin
            grp_p[k] = &p[k*GROUP +: GROUP];
            grp_g[k] = la(WIDTH'(p[k*GROUP +: GROUP]), WIDTH'(g[k*GROUP +: GROUP]), 1'b0, GROUP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c     <= 1'b0;
            s1_amsb  <= 1'b0;
            s1_bmsb  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p    <= p;
                s1_g    <= g;
                s1_gp   <= grp_p;
                s1_gg   <= grp_g;
                s1_c    <= c_eff;
                s1_amsb <= a[WIDTH-1];
                s1_bmsb <= b_eff[WIDTH-1];
            end
        end
    end

    // Second lookahead level: group carries from group P/G, then bit carries inside each group.
    always_comb begin
        gc = '0;
        c  = '0;
        for (int k = 0; k < NG; k++) gc[k] = la(WIDTH'(s1_gp), WIDTH'(s1_gg), s1_c, k);
        for (int k = 0; k < NG; k++)
            for (int j = 0; j < GROUP; j++)
                c[k*GROUP+j] = la(WIDTH'(s1_p[k*GROUP +: GROUP]), WIDTH'(s1_g[k*GROUP +: GROUP]), gc[k], j);
        nsum  = s1_p ^ c;
        ncout = (s1_amsb & s1_bmsb) | ((s1_amsb ^ s1_bmsb) & c[WIDTH-1]);
        novf  = c[WIDTH-1] ^ ncout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= nsum;
                cout <= ncout;
                ovf  <= novf;
                zero <= ~|nsum;
            end
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed checks of cla_adder_pipe (16-bit with GROUP 4/2/8, 32-bit stream)
module tb_cla_adder_pipe;
    logic        clk, rst_n, in_valid, out_ready, cin, sub;
    logic [15:0] a, b;
    logic [31:0] a32, b32;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [15:0] sum;
    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [15:0] sum2;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [15:0] sum8;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] sum32;

    int          ncmp = 0;
    int          nbad = 0;
    int          sent, got, occ, bubbles;
    logic        blocked, prev_stall;
    logic [16:0] held;
    logic [31:0] x, y;
    logic        s, ci, ov;
    logic [32:0] r;
    logic [34:0] tq[$];

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero));
    cla_adder_pipe #(.WIDTH(16), .GROUP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
        .cout(cout2), .ovf(ovf2), .zero(zero2));
    cla_adder_pipe #(.WIDTH(16), .GROUP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .cout(cout8), .ovf(ovf8), .zero(zero8));
    cla_adder_pipe #(.WIDTH(32), .GROUP(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .a(a32), .b(b32),
        .cin(cin), .sub(sub), .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bpa(input int i);
        return 16'h1357 * 16'(i + 1);
    endfunction

    function automatic logic [15:0] bpb(input int i);
        return 16'hF0F1 ^ 16'(i * 7);
    endfunction

    // One isolated beat through an empty pipeline: latency 2, all three group sizes agree.
    task automatic one(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic is, input logic ic, input logic [15:0] es,
                       input logic ec, input logic eo, input logic ez);
        a = ia; b = ib; sub = is; cin = ic; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        tick;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_g4"}, {sum, cout, ovf, zero}, {es, ec, eo, ez});
        chk({tag, "_g2"}, {out_valid2, sum2, cout2, ovf2, zero2}, {1'b1, es, ec, eo, ez});
        chk({tag, "_g8"}, {out_valid8, sum8, cout8, ovf8, zero8}, {1'b1, es, ec, eo, ez});
        tick;
        chk({tag, "_drain"}, out_valid, 0);
        chk({tag, "_retain"}, sum, es);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        a = '0; b = '0; a32 = '0; b32 = '0;
        tick;
        tick;
        chk("reset_out", {out_valid, sum, cout, ovf, zero}, 0);
        chk("reset_out32", {out_valid32, sum32, cout32, ovf32, zero32}, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);

        one("add",       16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        one("carry_all", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        one("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        one("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        one("sub_cin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0, 1'b0);
        one("add_ovf",   16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        one("sub_zero",  16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-pressure: 6 back-to-back beats, out_ready low for cycles 3..6.
        sent = 0; got = 0; blocked = 1'b0; prev_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            a = bpa(sent); b = bpb(sent); sub = 1'b0; cin = 1'b0;
            in_valid = (sent < 6);
            out_ready = !(cyc >= 3 && cyc < 7);
            @(negedge clk);
            occ = sent - got;
            chk("bp_in_ready", in_ready, (occ < 2) || out_ready);
            if (!in_ready) blocked = 1'b1;
            if (out_valid && !out_ready) begin
                if (prev_stall) chk("bp_hold", {cout, sum}, held);
                held = {cout, sum};
                prev_stall = 1'b1;
            end else prev_stall = 1'b0;
            if (out_valid && out_ready) begin
                chk("bp_order", {cout, sum}, {1'b0, bpa(got)} + {1'b0, bpb(got)});
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_blocked", blocked, 1);
        chk("bp_count", got, 6);
        tick;
        tick;
        chk("bp_no_dup", out_valid, 0);

        // Full throughput on the 32-bit instance.
        bubbles = 0; got = 0;
        for (int cyc = 0; cyc < 102; cyc++) begin
            x = $urandom;
            y = (cyc % 7 == 0) ? ~x : $urandom;
            s = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            a32 = x; b32 = y; sub = s; cin = ci;
            in_valid = (cyc < 100);
            @(negedge clk);
            if (cyc >= 2 && !out_valid32) bubbles++;
            if (out_valid32) begin
                if (tq.size() > 0) chk("tp_result", {cout32, ovf32, zero32, sum32}, tq.pop_front());
                else chk("tp_extra", out_valid32, 0);
                got++;
            end
            if (in_valid && in_ready32) begin
                r = s ? ({1'b0, x} + {1'b0, ~y} + 33'd1) : ({1'b0, x} + {1'b0, y} + {32'd0, ci});
                ov = s ? (x[31] != y[31] && r[31] != x[31]) : (x[31] == y[31] && r[31] != x[31]);
                tq.push_back({r[32], ov, r[31:0] == 32'd0, r[31:0]});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("tp_bubbles", bubbles, 0);
        chk("tp_count", got, 100);

        // Reset with two beats in flight.
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        tick;
        a = 16'h3333;
        tick;
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {out_valid, sum, cout, ovf, zero}, 0);
        chk("rst_in_ready", in_ready, 1);
        tick;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_no_stale", out_valid, 0);
        end
        one("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
